// File: rtl/tri_raster_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// types: shared triangle, vertex and bounding-box types for the raster scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package types;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vec3_i16;

    typedef struct packed {
        vec3_i16 v0;
        vec3_i16 v1;
        vec3_i16 v2;
    } tri_2d;

    typedef struct packed {
        logic [11:0] xmin;
        logic [11:0] xmax;
        logic [11:0] ymin;
        logic [11:0] ymax;
    } bbox_t;

    function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_raster_scheduler_bbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tri_bbox: combinational screen-clamped bounding box of three 12-bit vertices
// Rev 1.0
// ----------------------------------------------------------------------------
module tri_bbox import types::*; #(
    parameter int H_MAX = 1023,
    parameter int V_MAX = 767
) (
    input  logic [11:0] x0_i,
    input  logic [11:0] y0_i,
    input  logic [11:0] x1_i,
    input  logic [11:0] y1_i,
    input  logic [11:0] x2_i,
    input  logic [11:0] y2_i,
    output bbox_t       bbox_o,
    output logic        empty_o
);
    localparam logic [11:0] c_XLIM = 12'(H_MAX);
    localparam logic [11:0] c_YLIM = 12'(V_MAX);

    logic [11:0] w_xmin, w_xmax, w_ymin, w_ymax;

    assign w_xmin = min3(x0_i, x1_i, x2_i);
    assign w_xmax = max3(x0_i, x1_i, x2_i);
    assign w_ymin = min3(y0_i, y1_i, y2_i);
    assign w_ymax = max3(y0_i, y1_i, y2_i);

    assign bbox_o.xmin = w_xmin;
    assign bbox_o.ymin = w_ymin;
    assign bbox_o.xmax = (w_xmax > c_XLIM) ? c_XLIM : w_xmax;
    assign bbox_o.ymax = (w_ymax > c_YLIM) ? c_YLIM : w_ymax;
    // A box starting off-screen has nothing to scan even after clamping.
    assign empty_o     = (w_xmin > c_XLIM) || (w_ymin > c_YLIM);

endmodule
`default_nettype wire

// File: rtl/tri_raster_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tri_raster_scheduler: raster-scans a triangle's bounding box through a fill unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tri_raster_scheduler import types::*; #(
    parameter int H_MAX        = 1023,
    parameter int V_MAX        = 767,
    parameter int OUT_DEPTH    = 4,
    parameter int FILL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  tri_2d       tri_in,
    input  logic        tri_valid,
    output logic        tri_ready,
    output logic [11:0] fill_h,
    output logic [11:0] fill_v,
    output tri_2d       fill_tri,
    output logic        fill_issue,
    input  logic        fill_valid,
    input  logic        fill_within,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        done
);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int IW = $clog2(FILL_LATENCY + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_SCAN  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    tri_2d         fill_tri_q;
    bbox_t         bbox_q, w_bbox;
    logic          w_empty;
    logic [11:0]   h_q, h_d, v_q, v_d;
    logic [CW-1:0] inflight_q, inflight_d, count_q, count_d, w_used;
    logic [PW-1:0] head_q, tail_q;
    logic [11:0]   mem_x [OUT_DEPTH];
    logic [11:0]   mem_y [OUT_DEPTH];
    logic [11:0]   sh_h_q [FILL_LATENCY];
    logic [11:0]   sh_v_q [FILL_LATENCY];
    logic [IW-1:0] ign_q;
    logic          done_q, done_d;
    logic          w_issue, w_ret, w_push, w_pop;

    tri_bbox #(.H_MAX(H_MAX), .V_MAX(V_MAX)) u_bbox (
        .x0_i   (fill_tri_q.v0.x[11:0]),
        .y0_i   (fill_tri_q.v0.y[11:0]),
        .x1_i   (fill_tri_q.v1.x[11:0]),
        .y1_i   (fill_tri_q.v1.y[11:0]),
        .x2_i   (fill_tri_q.v2.x[11:0]),
        .y2_i   (fill_tri_q.v2.y[11:0]),
        .bbox_o (w_bbox),
        .empty_o(w_empty)
    );

    assign w_ret  = fill_valid && (ign_q == '0);
    assign w_push = w_ret && fill_within;
    assign w_pop  = (count_q != '0) && pix_ready;
    // The slot being popped this cycle is already free for a new credit.
    assign w_used  = (count_q - CW'(w_pop)) + inflight_q;
    assign w_issue = (state_q == c_SCAN) && (w_used < CW'(OUT_DEPTH));

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        done_d  = 1'b0;
        case (state_q)
            c_IDLE: if (tri_valid) state_d = c_SETUP;
            c_SETUP: begin
                if (w_empty) begin
                    state_d = c_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = c_SCAN;
                    h_d     = w_bbox.xmin;
                    v_d     = w_bbox.ymin;
                end
            end
            c_SCAN: begin
                if (w_issue) begin
                    if (h_q == bbox_q.xmax) begin
                        if (v_q == bbox_q.ymax) begin
                            state_d = c_DRAIN;
                        end else begin
                            h_d = bbox_q.xmin;
                            v_d = v_q + 12'd1;
                        end
                    end else begin
                        h_d = h_q + 12'd1;
                    end
                end
            end
            c_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = c_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (w_issue && !w_ret)      inflight_d = inflight_q + CW'(1);
        else if (!w_issue && w_ret) inflight_d = inflight_q - CW'(1);
        count_d = count_q;
        if (w_push && !w_pop)       count_d = count_q + CW'(1);
        else if (!w_push && w_pop)  count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            fill_tri_q <= '0;
            bbox_q     <= '0;
            h_q        <= '0;
            v_q        <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ign_q      <= IW'(FILL_LATENCY);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            v_q        <= v_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            done_q     <= done_d;
            if (state_q == c_IDLE && tri_valid) fill_tri_q <= tri_in;
            if (state_q == c_SETUP)             bbox_q     <= w_bbox;
            if (w_push)                         tail_q     <= tail_q + PW'(1);
            if (w_pop)                          head_q     <= head_q + PW'(1);
            if (ign_q != '0)                    ign_q      <= ign_q - IW'(1);
        end
    end

    // Coordinates ride alongside the fill unit so each return finds its own (h, v).
    always_ff @(posedge clk) begin
        sh_h_q[0] <= h_q;
        sh_v_q[0] <= v_q;
        for (int i = 1; i < FILL_LATENCY; i++) begin
            sh_h_q[i] <= sh_h_q[i-1];
            sh_v_q[i] <= sh_v_q[i-1];
        end
        if (w_push) begin
            mem_x[tail_q] <= sh_h_q[FILL_LATENCY-1];
            mem_y[tail_q] <= sh_v_q[FILL_LATENCY-1];
        end
    end

    assign tri_ready  = (state_q == c_IDLE);
    assign fill_h     = h_q;
    assign fill_v     = v_q;
    assign fill_tri   = fill_tri_q;
    assign fill_issue = w_issue;
    assign pix_valid  = (count_q != '0);
    assign pix_x      = pix_valid ? mem_x[head_q] : '0;
    assign pix_y      = pix_valid ? mem_y[head_q] : '0;
    assign done       = done_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (count_q == CW'(OUT_DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tri_raster_scheduler: vector table, corner sequences and random triangles
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_tri_raster_scheduler;
    import types::*;

    logic        clk = 1'b0;
    logic        rst;
    tri_2d       tri_in;
    logic        tri_valid;
    logic        tri_ready;
    logic [11:0] fill_h, fill_v;
    tri_2d       fill_tri;
    logic        fill_issue;
    logic        fill_valid, fill_within;
    logic [11:0] pix_x, pix_y;
    logic        pix_valid;
    logic        pix_ready;
    logic        done;

    always #5 clk = ~clk;

    tri_raster_scheduler #(
        .H_MAX(1023), .V_MAX(767), .OUT_DEPTH(4), .FILL_LATENCY(3)
    ) dut (
        .clk(clk), .rst(rst), .tri_in(tri_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .fill_h(fill_h), .fill_v(fill_v), .fill_tri(fill_tri), .fill_issue(fill_issue),
        .fill_valid(fill_valid), .fill_within(fill_within), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .done(done)
    );

    // Edge-function coverage test used both by the fill-unit model and the expectations
    function automatic bit in_tri(input tri_2d t, input int x, input int y);
        int ax, ay, bx, by, cx, cy, e0, e1, e2;
        ax = int'(t.v0.x[11:0]); ay = int'(t.v0.y[11:0]);
        bx = int'(t.v1.x[11:0]); by = int'(t.v1.y[11:0]);
        cx = int'(t.v2.x[11:0]); cy = int'(t.v2.y[11:0]);
        e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
        e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
        e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    // Fill unit: 3-cycle latency pipeline
    logic [2:0] pv = '0;
    logic [2:0] pw = '0;
    bit force_fv = 1'b0;
    always @(posedge clk) begin
        pv <= {pv[1:0], fill_issue};
        pw <= {pw[1:0], in_tri(fill_tri, int'(fill_h), int'(fill_v))};
    end
    assign fill_valid  = pv[2] | force_fv;
    assign fill_within = force_fv ? 1'b1 : pw[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    iss_h[$], iss_v[$], iss_c[$], pix_h[$], pix_v[$];
    int    done_cnt = 0, done_c = 0;
    bit    tri_bad = 1'b0;
    tri_2d cur_tri;

    always @(negedge clk) begin
        if (!rst) begin
            if (fill_issue) begin
                iss_h.push_back(int'(fill_h));
                iss_v.push_back(int'(fill_v));
                iss_c.push_back(cyc);
                if (fill_tri !== cur_tri) tri_bad = 1'b1;
            end
            if (pix_valid && pix_ready) begin
                pix_h.push_back(int'(pix_x));
                pix_v.push_back(int'(pix_y));
            end
            if (done) begin
                done_cnt++;
                done_c = cyc;
            end
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic tri_2d mk(input int x0, input int y0, input int x1, input int y1,
                                 input int x2, input int y2, input bit rh);
        tri_2d t;
        t.v0.x = {rh ? 4'($urandom) : 4'h0, 12'(x0)};
        t.v0.y = {rh ? 4'($urandom) : 4'h0, 12'(y0)};
        t.v1.x = {rh ? 4'($urandom) : 4'h0, 12'(x1)};
        t.v1.y = {rh ? 4'($urandom) : 4'h0, 12'(y1)};
        t.v2.x = {rh ? 4'($urandom) : 4'h0, 12'(x2)};
        t.v2.y = {rh ? 4'($urandom) : 4'h0, 12'(y2)};
        t.v0.z = 16'($urandom);
        t.v1.z = 16'($urandom);
        t.v2.z = 16'($urandom);
        return t;
    endfunction

    // mode 0: pix_ready=1; mode 1: pix_ready=0 for 20 cycles; mode 2: random pix_ready
    task automatic run_tri(input tri_2d t, input int mode, input int n_iss, input int n_pix,
                           input string nm);
        int eh[$], ev[$], ph[$], pvq[$];
        int xs[3], ys[3];
        int xmin, xmax, ymin, ymax, acc, n, bad;
        xs[0] = int'(t.v0.x[11:0]); xs[1] = int'(t.v1.x[11:0]); xs[2] = int'(t.v2.x[11:0]);
        ys[0] = int'(t.v0.y[11:0]); ys[1] = int'(t.v1.y[11:0]); ys[2] = int'(t.v2.y[11:0]);
        xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
        for (int i = 1; i < 3; i++) begin
            if (xs[i] < xmin) xmin = xs[i];
            if (xs[i] > xmax) xmax = xs[i];
            if (ys[i] < ymin) ymin = ys[i];
            if (ys[i] > ymax) ymax = ys[i];
        end
        if (xmax > 1023) xmax = 1023;
        if (ymax > 767) ymax = 767;
        if (xmin <= 1023 && ymin <= 767) begin
            for (int y = ymin; y <= ymax; y++)
                for (int x = xmin; x <= xmax; x++) begin
                    eh.push_back(x); ev.push_back(y);
                    if (in_tri(t, x, y)) begin ph.push_back(x); pvq.push_back(y); end
                end
        end

        @(posedge clk); #1;
        iss_h.delete(); iss_v.delete(); iss_c.delete(); pix_h.delete(); pix_v.delete();
        done_cnt = 0; tri_bad = 1'b0; cur_tri = t;
        tri_in = t; tri_valid = 1'b1; pix_ready = (mode != 1); acc = cyc;
        @(posedge clk); #1;
        tri_valid = 1'b0; tri_in = ~t;
        n = 0;
        while (n < 3000) begin
            if (mode == 1 && n == 20) begin
                chk({nm, " stalled issues"}, iss_h.size(), 4);
                chk({nm, " stalled pix_valid"}, int'(pix_valid), 1);
                chk({nm, " stalled done"}, done_cnt, 0);
                pix_ready = 1'b1;
            end
            if (mode == 2) pix_ready = 1'($urandom);
            if (mode != 1 || n > 20)
                if (done_cnt > 0 && !pix_valid) break;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " completed in budget"}, int'(n < 3000), 1);
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        if (n_iss >= 0) chk({nm, " issue count"}, iss_h.size(), n_iss);
        if (n_pix >= 0) chk({nm, " pixel count"}, pix_h.size(), n_pix);
        chk({nm, " model issue count"}, iss_h.size(), eh.size());
        chk({nm, " model pixel count"}, pix_h.size(), ph.size());
        bad = 0;
        for (int i = 0; i < eh.size() && i < iss_h.size(); i++)
            if (iss_h[i] != eh[i] || iss_v[i] != ev[i]) bad++;
        chk({nm, " issue order"}, bad, 0);
        bad = 0;
        for (int i = 0; i < ph.size() && i < pix_h.size(); i++)
            if (pix_h[i] != ph[i] || pix_v[i] != pvq[i]) bad++;
        chk({nm, " pixel order"}, bad, 0);
        chk({nm, " done pulses"}, done_cnt, 1);
        chk({nm, " fill_tri stable"}, int'(tri_bad), 0);
        if (mode == 0 && eh.size() > 0 && iss_c.size() > 0) begin
            chk({nm, " first issue latency"}, iss_c[0] - acc, 2);
            chk({nm, " issue span"}, iss_c[iss_c.size()-1] - iss_c[0], eh.size() - 1);
        end
        if (eh.size() == 0) chk({nm, " done latency"}, done_c - acc, 2);
    endtask

    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int mode;
        int n_iss;
        int n_pix;
    } vec_t;

    vec_t  tab[6];
    tri_2d t;
    bit    seen;

    initial begin
        tab[0] = '{10, 10, 12, 10, 10, 12, 0, 9, 6};
        tab[1] = '{10, 10, 12, 10, 10, 12, 1, 9, 6};
        tab[2] = '{2000, 5, 2001, 5, 2002, 6, 0, 0, 0};
        tab[3] = '{1020, 0, 1030, 0, 1020, 1, 0, 8, 5};
        tab[4] = '{50, 60, 50, 60, 50, 60, 0, 1, 1};
        tab[5] = '{5, 800, 6, 801, 7, 802, 0, 0, 0};

        rst = 1'b1; tri_in = '0; tri_valid = 1'b0; pix_ready = 1'b1; cur_tri = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tri_ready", int'(tri_ready), 1);
        chk("reset pix_valid", int'(pix_valid), 0);
        chk("reset fill_issue", int'(fill_issue), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            t = mk(tab[i].x0, tab[i].y0, tab[i].x1, tab[i].y1, tab[i].x2, tab[i].y2, 1'b0);
            run_tri(t, tab[i].mode, tab[i].n_iss, tab[i].n_pix, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a scan, followed by stale fill returns
        t = mk(0, 0, 20, 0, 0, 20, 1'b0);
        @(posedge clk); #1;
        cur_tri = t; tri_in = t; tri_valid = 1'b1; pix_ready = 1'b1;
        @(posedge clk); #1;
        tri_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midscan issuing", int'(fill_issue), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; force_fv = 1'b1;
        chk("rst tri_ready", int'(tri_ready), 1);
        chk("rst pix_valid", int'(pix_valid), 0);
        chk("rst fill_issue", int'(fill_issue), 0);
        chk("rst done", int'(done), 0);
        chk("rst fill_h", int'(fill_h), 0);
        chk("rst fill_v", int'(fill_v), 0);
        chk("rst pix_x", int'(pix_x), 0);
        chk("rst pix_y", int'(pix_y), 0);
        chk("rst fill_tri cleared", int'(fill_tri == '0), 1);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen |= pix_valid;
        end
        force_fv = 1'b0;
        chk("late fill_valid ignored", int'(seen), 0);
        t = mk(10, 10, 12, 10, 10, 12, 1'b0);
        run_tri(t, 0, 9, 6, "after rst");

        for (int i = 0; i < 25; i++) begin
            int bx, by;
            bx = int'($urandom_range(0, 1100));
            by = int'($urandom_range(0, 800));
            t = mk(bx + int'($urandom_range(0, 6)), by + int'($urandom_range(0, 6)),
                   bx + int'($urandom_range(0, 6)), by + int'($urandom_range(0, 6)),
                   bx + int'($urandom_range(0, 6)), by + int'($urandom_range(0, 6)), 1'b1);
            run_tri(t, 2, -1, -1, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tri_raster_scheduler.md
TRI_RASTER_SCHEDULER -- requirements
Module: tri_raster_scheduler

Interface
REQ-001 SHALL have parameter H_MAX, default 1023, meaning last valid screen column.
REQ-002 SHALL have parameter V_MAX, default 767, meaning last valid screen row.
REQ-003 SHALL have parameter OUT_DEPTH, default 4, meaning output FIFO entries, power of two, minimum 4.
REQ-004 SHALL have parameter FILL_LATENCY, default 3, meaning cycles from fill issue to fill result.
REQ-005 SHALL have ports as listed below, one clock and one synchronous active-high reset.
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- tri_in  in  tri_2d  triangle to rasterize; x, y taken from bits [11:0] of each vertex.
- tri_valid  in  1  tri_in is valid.
- tri_ready  out  1  block accepts tri_in this cycle.
- fill_h  out  12  column driven to the fill unit.
- fill_v  out  12  row driven to the fill unit.
- fill_tri  out  tri_2d  latched triangle driven to the fill unit.
- fill_issue  out  1  fill_h/fill_v are valid this cycle.
- fill_valid  in  1  fill result valid.
- fill_within  in  1  fill result is inside the triangle.
- pix_x  out  12  covered pixel column.
- pix_y  out  12  covered pixel row.
- pix_valid  out  1  output FIFO head is valid.
- pix_ready  in  1  downstream consumes the head.
- done  out  1  one-cycle pulse when a triangle completes.

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, SCAN and DRAIN.
REQ-007 IDLE SHALL assert tri_ready; on tri_valid it SHALL latch tri_in into fill_tri and go to SETUP.
REQ-008 SETUP (1 cycle) SHALL register the bounding box:
- xmin/xmax/ymin/ymax are the min/max of the three vertex coordinates, unsigned 12-bit.
- xmax is clamped to H_MAX and ymax to V_MAX.
- If xmin>H_MAX or ymin>V_MAX, the FSM SHALL go to IDLE and pulse done; otherwise it goes to SCAN with h=xmin, v=ymin.
REQ-009 SCAN SHALL issue at most one pixel per cycle in raster order:
- Issue runs h from xmin to xmax, then v+1 with h=xmin.
- fill_issue SHALL be asserted only when fifo_count + inflight < OUT_DEPTH, where inflight counts issues not yet returned by fill_valid.
REQ-010 After issuing (xmax, ymax), the FSM SHALL go to DRAIN.
REQ-011 DRAIN SHALL wait until inflight==0, then pulse done and go to IDLE.
REQ-012 fill_tri SHALL remain stable from SETUP through DRAIN.
REQ-013 tri_ready SHALL be 0 outside IDLE.
REQ-014 Each fill_valid SHALL decrement inflight by 1.
REQ-015 If fill_within=1 on fill_valid, the block SHALL push the returned (h, v) into the output FIFO.
- Coordinates come from an internal FILL_LATENCY-deep shift register aligned with issue.
REQ-016 On a simultaneous issue and return, inflight SHALL be unchanged.
REQ-017 On a simultaneous push and pop, fifo_count SHALL be unchanged.
REQ-018 FIFO overflow SHALL be impossible by construction; a push into a full FIFO is a verification assertion failure.
REQ-019 pix_valid SHALL equal fifo_count != 0, and pix_x/pix_y SHALL show the FIFO head.
REQ-020 A pop SHALL occur on pix_valid && pix_ready.
REQ-021 Pixels SHALL leave the FIFO in issue order.
REQ-022 A degenerate triangle (all vertices equal) SHALL issue exactly one pixel.
REQ-023 Throughput with pix_ready held at 1 SHALL be one issue per cycle after SETUP.

Reset
REQ-024 On rst, the block SHALL do all of the following on the next edge, including mid-SCAN or mid-DRAIN:
- FSM to IDLE.
- inflight=0 and fifo_count=0.
- fill_issue=0, pix_valid=0, done=0, tri_ready=1.
- pix_x, pix_y, fill_h and fill_v set to 0.
- fill_tri cleared.
REQ-025 The block SHALL ignore fill_valid during rst and during the FILL_LATENCY cycles after rst deasserts.

Structure
REQ-026 tri_2d, vec3_i16 and a bbox_t struct {xmin, xmax, ymin, ymax: 12-bit} SHALL reside in package types.
REQ-027 Bounding-box min/max/clamp logic SHALL be the single sub-module tri_bbox, which is combinational and registered in SETUP.
REQ-028 The output FIFO SHALL be inline, as a register array with head and tail pointers.

Verification
REQ-029 The bench SHALL use a fill-unit model with a 3-cycle latency and SHALL cover these scenarios:
- Triangle (10,10),(12,10),(10,12), pix_ready=1: 9 issues in 9 consecutive cycles after SETUP; 6 pixels out in raster order; done pulses once.
- Same triangle with pix_ready=0: issue stalls after 4 issues; no pixel lost; releasing pix_ready produces all 6 pixels.
- Vertices (2000,5),(2001,5),(2002,6): 0 issues; done pulses 2 cycles after accept.
- Vertices (1020,0),(1030,0),(1020,1): xmax clamped to 1023; issues cover h 1020..1023 over 2 rows.
- rst asserted mid-SCAN: next cycle IDLE, pix_valid=0, tri_ready=1; late fill_valid pulses ignored; a new triangle then completes correctly.
- Degenerate (50,60)x3: exactly 1 issue; pixel (50,60) out if fill_within=1.
